// File: rtl/TicSAT_pkg.sv
// Shared types for the systolic-array input staging logic.
package TicSAT_pkg;

    // IDLE: nothing held; ACTIVE: data staged, pending or in flight; DRAIN: flushing out.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } skew_state_t;

endpackage

// File: rtl/sa_lane_delay.sv
// Enable-gated shift chain carrying one lane's data and valid bit.
// Tail register drives the outputs directly; any_valid reports whether
// any stage of the chain still holds valid data.
module sa_lane_delay
    import TicSAT_pkg::*;
#(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              any_valid
);

    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [DEPTH-1:0]             vld_q, vld_d;

    // Shift one position toward the tail only when the consumer advances.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (en) begin
            data_d[0] = in_data;
            vld_d[0]  = in_valid;
            for (int j = 1; j < DEPTH; j++) begin
                data_d[j] = data_q[j-1];
                vld_d[j]  = vld_q[j-1];
            end
        end
    end

    // Chain registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            vld_q  <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign out_data  = data_q[DEPTH-1];
    assign out_valid = vld_q[DEPTH-1];
    assign any_valid = |vld_q;

endmodule

// File: rtl/sa_skew_stream.sv
// Stages indexed activation elements into a row, holds one committed row
// pending, and feeds it into per-lane delay chains so lane i lags lane 0
// by i consumer advances (when skewing is enabled).
//
//   state  | meaning
//   IDLE   | nothing staged, pending or in flight
//   ACTIVE | data staged, pending or in flight
//   DRAIN  | flush requested; no input accepted, emptying out
module sa_skew_stream
    import TicSAT_pkg::*;
#(
    parameter int SA_SIZE = 4,
    parameter int DATA_W  = 32,
    parameter int SKEW_EN = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_W-1:0]                in_data,
    input  logic [$clog2(SA_SIZE)-1:0]       in_idx,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    input  logic                             flush,
    input  logic                             out_advance,
    output logic [SA_SIZE-1:0][DATA_W-1:0]   out_data,
    output logic [SA_SIZE-1:0]               out_lane_valid,
    output logic                             busy,
    output logic                             flush_done
);

    localparam logic [SA_SIZE-1:0] FULL_MASK = '1;

    skew_state_t state_q, state_d;

    logic [SA_SIZE-1:0][DATA_W-1:0] stage_q, stage_d;
    logic [SA_SIZE-1:0][DATA_W-1:0] pend_q, pend_d;
    logic [SA_SIZE-1:0][DATA_W-1:0] head_data;
    logic [SA_SIZE-1:0]             mask_q, mask_d;
    logic [SA_SIZE-1:0]             wr_mask;
    logic [SA_SIZE-1:0]             lane_any;
    logic                           pend_v_q, pend_v_d;
    logic                           idle_flush_q, idle_flush_d;
    logic                           head_valid;
    logic                           accept;
    logic                           commit;

    assign in_ready = !pend_v_q && (state_q != DRAIN);
    assign accept   = in_valid && in_ready;
    assign busy     = (|mask_q) || pend_v_q || (|lane_any);

    // The pending row is injected on an advance; an empty slot becomes a bubble.
    assign head_data  = pend_v_q ? pend_q : '0;
    assign head_valid = pend_v_q;

    // A drain completes the cycle everything is empty; a flush seen in IDLE
    // is answered one cycle later.
    assign flush_done = idle_flush_q || ((state_q == DRAIN) && !busy);

    // Stage writes, row commit and pending-slot bookkeeping.
    always_comb begin
        wr_mask = '0;
        if (accept && (32'(in_idx) < SA_SIZE)) begin
            wr_mask[in_idx] = 1'b1;
        end

        stage_d = stage_q;
        mask_d  = mask_q | wr_mask;
        for (int i = 0; i < SA_SIZE; i++) begin
            if (wr_mask[i]) begin
                stage_d[i] = in_data;
            end
        end

        commit = (accept && (in_last || (mask_d == FULL_MASK))) ||
                 ((state_q == DRAIN) && (mask_q != '0) && !pend_v_q);

        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        if (out_advance) begin
            pend_v_d = 1'b0;
        end
        // Unwritten lanes are already zero because the stage is cleared on commit.
        if (commit) begin
            pend_d   = stage_d;
            pend_v_d = 1'b1;
            stage_d  = '0;
            mask_d   = '0;
        end
    end

    // Next-state logic for the sequencing FSM.
    always_comb begin
        state_d      = state_q;
        idle_flush_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    if (accept) state_d = DRAIN;
                    else        idle_flush_d = 1'b1;
                end else if (accept) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (flush)                 state_d = DRAIN;
                else if (!busy && !accept) state_d = IDLE;
            end
            DRAIN: begin
                if (!busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and staging registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            stage_q      <= '0;
            mask_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            idle_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_q      <= stage_d;
            mask_q       <= mask_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            idle_flush_q <= idle_flush_d;
        end
    end

    for (genvar i = 0; i < SA_SIZE; i++) begin : g_lane
        localparam int DEPTH = (SKEW_EN != 0) ? (i + 1) : 1;
        sa_lane_delay #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .en        (out_advance),
            .in_data   (head_data[i]),
            .in_valid  (head_valid),
            .out_data  (out_data[i]),
            .out_valid (out_lane_valid[i]),
            .any_valid (lane_any[i])
        );
    end

endmodule

// File: tb/tb_sa_skew_stream.sv
// Directed bench: a skewed instance and an aligned instance share stimulus.
module tb_sa_skew_stream;

    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, in_valid, in_last, flush, out_advance;
    logic [W-1:0]     in_data;
    logic [1:0]       in_idx;

    logic             in_ready, busy, flush_done;
    logic [N-1:0][W-1:0] out_data;
    logic [N-1:0]     out_lane_valid;

    logic             in_ready_ns, busy_ns, flush_done_ns;
    logic [N-1:0][W-1:0] out_data_ns;
    logic [N-1:0]     out_lane_valid_ns;

    int checks   = 0;
    int failures = 0;

    sa_skew_stream #(.SA_SIZE(N), .DATA_W(W), .SKEW_EN(1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_idx(in_idx),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .flush(flush), .out_advance(out_advance), .out_data(out_data),
        .out_lane_valid(out_lane_valid), .busy(busy), .flush_done(flush_done)
    );

    sa_skew_stream #(.SA_SIZE(N), .DATA_W(W), .SKEW_EN(0)) dut_ns (
        .clk(clk), .reset(reset), .in_data(in_data), .in_idx(in_idx),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_ns),
        .flush(flush), .out_advance(out_advance), .out_data(out_data_ns),
        .out_lane_valid(out_lane_valid_ns), .busy(busy_ns), .flush_done(flush_done_ns)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_elem(input int idx, input int data, input logic last);
        in_idx   = idx[1:0];
        in_data  = data;
        in_last  = last;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic advance();
        out_advance = 1'b1;
        step();
        out_advance = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        checks++; if (out_lane_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid: got %b expected 0000", out_lane_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL reset_flush_done: got %b expected 0", flush_done); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_full_row();
        logic [N-1:0] ev;
        for (int i = 0; i < N; i++) write_elem(i, i + 1, 1'b0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_row_pending_ready: got %b expected 0", in_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_row_busy: got %b expected 1", busy); end
        for (int k = 1; k <= 5; k++) begin
            advance();
            ev = (k <= 4) ? 4'(1 << (k - 1)) : 4'b0000;
            checks++; if (out_lane_valid !== ev) begin failures++; $display("FAIL full_row_valid adv%0d: got %b expected %b", k, out_lane_valid, ev); end
            if (k <= 4) begin
                checks++; if (out_data[k-1] !== W'(k)) begin failures++; $display("FAIL full_row_data adv%0d: got %0d expected %0d", k, out_data[k-1], k); end
            end
        end
        step();
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_row_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_early_close();
        logic [N-1:0] ev;
        logic [W-1:0] ed;
        write_elem(1, 7, 1'b1);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL early_close_commit: in_ready got %b expected 0", in_ready); end
        for (int k = 1; k <= 4; k++) begin
            advance();
            ev = 4'(1 << (k - 1));
            ed = (k == 2) ? 32'd7 : 32'd0;
            checks++; if (out_lane_valid !== ev) begin failures++; $display("FAIL early_close_valid adv%0d: got %b expected %b", k, out_lane_valid, ev); end
            checks++; if (out_data[k-1] !== ed) begin failures++; $display("FAIL early_close_data adv%0d: got %0d expected %0d", k, out_data[k-1], ed); end
        end
        advance();
        checks++; if (out_lane_valid !== 4'b0000) begin failures++; $display("FAIL early_close_tail: got %b expected 0000", out_lane_valid); end
        step();
        step();
    endtask

    task automatic test_backpressure();
        write_elem(0, 11, 1'b1);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_first_commit_ready: got %b expected 0", in_ready); end
        advance();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_after_adv1_ready: got %b expected 1", in_ready); end
        write_elem(0, 12, 1'b1);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_second_commit_ready: got %b expected 0", in_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy: got %b expected 1", busy); end
        advance();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_after_adv2_ready: got %b expected 1", in_ready); end
        checks++; if (!(out_lane_valid[0] === 1'b1 && out_data[0] === 32'd12)) begin failures++; $display("FAIL bp_lane0_row2: got valid %b data %0d expected valid 1 data 12", out_lane_valid[0], out_data[0]); end
        for (int k = 0; k < 5; k++) advance();
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_drained_busy: got %b expected 0", busy); end
    endtask

    task automatic test_flush();
        int lane0_at, lane3_at, fd_at, fd_count;
        logic busy_at_fd;
        lane0_at = -1; lane3_at = -1; fd_at = -1; fd_count = 0; busy_at_fd = 1'bx;
        write_elem(0, 5, 1'b0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_staged_busy: got %b expected 1", busy); end
        flush       = 1'b1;
        out_advance = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_drain_ready: got %b expected 0", in_ready); end
        for (int s = 1; s <= 15; s++) begin
            step();
            if (out_lane_valid[0] === 1'b1 && out_data[0] === 32'd5) lane0_at = s;
            if (out_lane_valid[3] === 1'b1) lane3_at = s;
            if (flush_done === 1'b1) begin
                fd_count++;
                fd_at      = s;
                busy_at_fd = busy;
            end
        end
        out_advance = 1'b0;
        checks++; if (lane0_at !== 2) begin failures++; $display("FAIL flush_lane0_5: got step %0d expected step 2", lane0_at); end
        checks++; if (lane3_at !== 5) begin failures++; $display("FAIL flush_lane3_valid: got step %0d expected step 5", lane3_at); end
        checks++; if (fd_count !== 1) begin failures++; $display("FAIL flush_done_count: got %0d expected 1", fd_count); end
        checks++; if (fd_at !== 6) begin failures++; $display("FAIL flush_done_step: got %0d expected 6", fd_at); end
        checks++; if (busy_at_fd !== 1'b0) begin failures++; $display("FAIL flush_busy_at_done: got %b expected 0", busy_at_fd); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_idle_ready: got %b expected 1", in_ready); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (flush_done !== 1'b1) begin failures++; $display("FAIL idle_flush_pulse: got %b expected 1", flush_done); end
        step();
        checks++; if (flush_done !== 1'b0) begin failures++; $display("FAIL idle_flush_single: got %b expected 0", flush_done); end
    endtask

    task automatic test_no_skew();
        logic [N-1:0][W-1:0] exp_row;
        exp_row[0] = 32'd9; exp_row[1] = 32'd8; exp_row[2] = 32'd7; exp_row[3] = 32'd6;
        for (int i = 0; i < N; i++) write_elem(i, 9 - i, 1'b0);
        advance();
        checks++; if (out_lane_valid_ns !== 4'b1111) begin failures++; $display("FAIL noskew_valid: got %b expected 1111", out_lane_valid_ns); end
        checks++; if (out_data_ns !== exp_row) begin failures++; $display("FAIL noskew_data: got %0h expected %0h", out_data_ns, exp_row); end
        checks++; if (!(out_lane_valid === 4'b0001 && out_data[0] === 32'd9)) begin failures++; $display("FAIL skew_lane0_only: got valid %b data %0d expected 0001 and 9", out_lane_valid, out_data[0]); end
        advance();
        checks++; if (out_lane_valid_ns !== 4'b0000) begin failures++; $display("FAIL noskew_single_adv: got %b expected 0000", out_lane_valid_ns); end
        for (int k = 0; k < 4; k++) advance();
        step();
        step();
    endtask

    task automatic test_reset_mid_row();
        int fd_seen;
        fd_seen = 0;
        write_elem(0, 21, 1'b0);
        write_elem(2, 23, 1'b0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrow_busy: got %b expected 1", busy); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (out_data !== '0) begin failures++; $display("FAIL midrow_out_data: got %0h expected 0", out_data); end
        checks++; if (out_lane_valid !== 4'b0000) begin failures++; $display("FAIL midrow_valid: got %b expected 0000", out_lane_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrow_busy_clear: got %b expected 0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrow_ready: got %b expected 1", in_ready); end
        for (int s = 0; s < 5; s++) begin
            if (flush_done === 1'b1) fd_seen++;
            step();
        end
        checks++; if (fd_seen !== 0) begin failures++; $display("FAIL midrow_no_flush_done: got %0d pulses expected 0", fd_seen); end
        test_full_row();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
        out_advance = 1'b0; in_data = '0; in_idx = '0;
        test_reset();
        test_full_row();
        test_early_close();
        test_backpressure();
        test_flush();
        test_no_skew();
        test_reset_mid_row();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
